// File: rtl/simplerisc_mc_core.sv
// simplerisc_mc_core - multi-cycle SimpleRISC core with req/ack memory buses.
//
// Each instruction walks FETCH -> EXEC (-> MEM for ld/st) -> FETCH. The
// buses are plain req/ack handshakes, so slow memories stretch FETCH or MEM
// by withholding ack; address/data are held stable until ack is sampled.
//
// Parameters:
//   RESET_PC        PC loaded on reset
//   ADDR_W          width of ibus_addr / dbus_addr (low bits of byte address)
//   HALT_ON_ILLEGAL 1: opcodes 21..31 halt the core, 0: they act as nop
//
// Ports:
//   clk, rstn                      clock (rising edge), async active-low reset
//   ibus_req/addr/ack/rdata        instruction fetch bus
//   dbus_req/we/addr/wdata/ack/rdata  data bus (we=1 store, we=0 load)
//   retire                         one-cycle pulse per completed instruction
//   halted                         core stopped on an illegal opcode
//   alu_debug                      registered result of the last ALU-class op
//   cyc_count, instret             performance counters
//
// Optional feature: define SRISC_PERF_CNT_EN to build cyc_count/instret
// counters; otherwise both outputs are tied to zero.

module simplerisc_mc_core #(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter int          ADDR_W          = 32,
    parameter int          HALT_ON_ILLEGAL = 1
) (
    input  logic              clk,
    input  logic              rstn,
    output logic              ibus_req,
    output logic [ADDR_W-1:0] ibus_addr,
    input  logic              ibus_ack,
    input  logic [31:0]       ibus_rdata,
    output logic              dbus_req,
    output logic              dbus_we,
    output logic [ADDR_W-1:0] dbus_addr,
    output logic [31:0]       dbus_wdata,
    input  logic              dbus_ack,
    input  logic [31:0]       dbus_rdata,
    output logic              retire,
    output logic              halted,
    output logic [31:0]       alu_debug,
    output logic [31:0]       cyc_count,
    output logic [31:0]       instret
);

    localparam logic [4:0] OP_ADD = 5'd0,  OP_SUB = 5'd1,  OP_MUL = 5'd2,
                           OP_DIV = 5'd3,  OP_MOD = 5'd4,  OP_CMP = 5'd5,
                           OP_AND = 5'd6,  OP_OR  = 5'd7,  OP_NOT = 5'd8,
                           OP_MOV = 5'd9,  OP_LSL = 5'd10, OP_LSR = 5'd11,
                           OP_ASR = 5'd12, OP_NOP = 5'd13, OP_LD  = 5'd14,
                           OP_ST  = 5'd15, OP_BEQ = 5'd16, OP_BGT = 5'd17,
                           OP_B   = 5'd18, OP_CALL = 5'd19, OP_RET = 5'd20;

    typedef enum logic [1:0] {S_FETCH, S_EXEC, S_MEM, S_HALT} state_t;

    state_t      state, state_nxt;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] regs [0:15];
    logic        flag_e, flag_gt;

    // Signed divide/modulo pin the two cases the divider cannot produce:
    // divide by zero, and INT_MIN / -1 which wraps back to INT_MIN.
    function automatic logic [31:0] alu_op(input logic [4:0] op,
                                           input logic signed [31:0] a,
                                           input logic signed [31:0] b);
        logic [31:0] r;
        case (op)
            OP_ADD:         r = a + b;
            OP_SUB, OP_CMP: r = a - b;
            OP_MUL:         r = a * b;
            OP_DIV: begin
                if (b == 32'sd0)                                   r = 32'hFFFF_FFFF;
                else if (a == 32'sh8000_0000 && b == -32'sd1)      r = a;
                else                                               r = a / b;
            end
            OP_MOD: begin
                if (b == 32'sd0)                                   r = a;
                else if (a == 32'sh8000_0000 && b == -32'sd1)      r = 32'h0;
                else                                               r = a % b;
            end
            OP_AND:         r = a & b;
            OP_OR:          r = a | b;
            OP_NOT:         r = ~b;
            OP_MOV:         r = b;
            OP_LSL:         r = a << b[4:0];
            OP_LSR:         r = a >> b[4:0];
            OP_ASR:         r = a >>> b[4:0];
            default:        r = a + b;
        endcase
        return r;
    endfunction

    // Decode of the latched instruction
    logic [4:0]         op;
    logic [3:0]         rd, rs1, rs2;
    logic [31:0]        immx, rs1_val, rs2_val, rd_val, opb, alu_res;
    logic [31:0]        pc_plus4, target, mem_addr;
    logic signed [31:0] rs1_s, opb_s;
    logic               halt_now;

    assign op  = instr[31:27];
    assign rd  = instr[25:22];
    assign rs1 = instr[21:18];
    assign rs2 = instr[17:14];

    always_comb begin
        case (instr[17:16])
            2'b01:   immx = {16'h0000, instr[15:0]};
            2'b10:   immx = {instr[15:0], 16'h0000};
            default: immx = {{16{instr[15]}}, instr[15:0]};
        endcase
    end

    assign rs1_val  = regs[rs1];
    assign rs2_val  = regs[rs2];
    assign rd_val   = regs[rd];
    assign opb      = instr[26] ? immx : rs2_val;
    assign rs1_s    = rs1_val;
    assign opb_s    = opb;
    assign alu_res  = alu_op(op, rs1_s, opb_s);
    assign pc_plus4 = pc + 32'd4;
    assign target   = pc + {{3{instr[26]}}, instr[26:0], 2'b00};
    assign mem_addr = rs1_val + immx;
    assign halt_now = (op > OP_RET) && (HALT_ON_ILLEGAL != 0);

    // Control: state register and next-state / handshake decode
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= S_FETCH;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        retire    = 1'b0;
        case (state)
            S_FETCH: if (ibus_ack) state_nxt = S_EXEC;
            S_EXEC: begin
                if (halt_now)                        state_nxt = S_HALT;
                else if (op == OP_LD || op == OP_ST) state_nxt = S_MEM;
                else begin
                    state_nxt = S_FETCH;
                    retire    = 1'b1;
                end
            end
            S_MEM: if (dbus_ack) begin
                state_nxt = S_FETCH;
                retire    = 1'b1;
            end
            default: state_nxt = S_HALT;
        endcase
    end

    // The reset term drops ibus_req the moment rstn falls, even though the
    // state register already sits in FETCH during reset.
    assign ibus_req  = rstn && (state == S_FETCH);
    assign ibus_addr = pc[ADDR_W-1:0];
    assign dbus_req  = (state == S_MEM);
    assign halted    = (state == S_HALT);

    // Datapath: fetch latch, execute, memory writeback
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pc         <= RESET_PC;
            instr      <= '0;
            flag_e     <= 1'b0;
            flag_gt    <= 1'b0;
            alu_debug  <= '0;
            dbus_we    <= 1'b0;
            dbus_addr  <= '0;
            dbus_wdata <= '0;
            for (int i = 0; i < 16; i++) regs[i] <= '0;
        end else begin
            if (state == S_FETCH && ibus_ack) instr <= ibus_rdata;

            if (state == S_EXEC) begin
                case (op)
                    OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_MOD, OP_AND, OP_OR,
                    OP_NOT, OP_MOV, OP_LSL, OP_LSR, OP_ASR: begin
                        regs[rd]  <= alu_res;
                        alu_debug <= alu_res;
                        pc        <= pc_plus4;
                    end
                    OP_CMP: begin
                        flag_e    <= (rs1_val == opb);
                        flag_gt   <= (rs1_s > opb_s);
                        alu_debug <= alu_res;
                        pc        <= pc_plus4;
                    end
                    OP_BEQ:  pc <= flag_e  ? target : pc_plus4;
                    OP_BGT:  pc <= flag_gt ? target : pc_plus4;
                    OP_B:    pc <= target;
                    OP_CALL: begin
                        regs[15] <= pc_plus4;
                        pc       <= target;
                    end
                    OP_RET:  pc <= regs[15];
                    OP_LD, OP_ST: begin
                        dbus_we    <= (op == OP_ST);
                        dbus_addr  <= mem_addr[ADDR_W-1:0];
                        dbus_wdata <= rd_val;
                    end
                    OP_NOP:  pc <= pc_plus4;
                    default: if (!halt_now) pc <= pc_plus4;
                endcase
            end

            if (state == S_MEM && dbus_ack) begin
                if (!dbus_we) regs[rd] <= dbus_rdata;
                pc <= pc_plus4;
            end
        end
    end

`ifdef SRISC_PERF_CNT_EN
    logic [31:0] cyc_q, instret_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cyc_q     <= '0;
            instret_q <= '0;
        end else begin
            if (state != S_HALT) cyc_q <= cyc_q + 32'd1;
            if (retire)          instret_q <= instret_q + 32'd1;
        end
    end

    assign cyc_count = cyc_q;
    assign instret   = instret_q;
`else
    assign cyc_count = '0;
    assign instret   = '0;
`endif

endmodule

// File: tb/tb_simplerisc_mc_core.sv
// Testbench for simplerisc_mc_core: wait-state bus models, ALU vector table
// and hand-written programs for timing, branching, memory, halt and reset.

module tb_simplerisc_mc_core;

    logic        clk = 1'b0;
    logic        rstn;
    logic        ibus_req, ibus_ack;
    logic [31:0] ibus_addr, ibus_rdata;
    logic        dbus_req, dbus_we, dbus_ack;
    logic [31:0] dbus_addr, dbus_wdata, dbus_rdata;
    logic        retire, halted;
    logic [31:0] alu_debug, cyc_count, instret;

    localparam logic [31:0] HALT_W = 32'hF800_0000;

    always #5 clk = ~clk;

    simplerisc_mc_core dut (
        .clk(clk), .rstn(rstn),
        .ibus_req(ibus_req), .ibus_addr(ibus_addr), .ibus_ack(ibus_ack), .ibus_rdata(ibus_rdata),
        .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr), .dbus_wdata(dbus_wdata),
        .dbus_ack(dbus_ack), .dbus_rdata(dbus_rdata),
        .retire(retire), .halted(halted), .alu_debug(alu_debug),
        .cyc_count(cyc_count), .instret(instret)
    );

    // Memory models: ack after iwait/dwait wait cycles, only while req is high
    logic [31:0] imem [0:255];
    int          iwait = 0, dwait = 0, iw_cnt = 0, dw_cnt = 0;
    logic [31:0] ld_data = 32'h0;

    assign ibus_ack   = ibus_req && (iw_cnt == iwait);
    assign ibus_rdata = imem[ibus_addr[9:2]];
    assign dbus_ack   = dbus_req && (dw_cnt == dwait);
    assign dbus_rdata = ld_data;

    always @(posedge clk) begin
        iw_cnt <= (rstn && ibus_req && !ibus_ack) ? iw_cnt + 1 : 0;
        dw_cnt <= (rstn && dbus_req && !dbus_ack) ? dw_cnt + 1 : 0;
    end

    // Observation log, cleared while reset is held
    int          cyc_n, ret_cnt, nf, nd, irun, drun, max_irun, max_drun, iaddr_bad;
    logic [31:0] irun_addr;
    int          rcyc [0:31];
    logic [31:0] flog [0:31];
    logic [31:0] dlog_addr [0:15];
    logic [31:0] dlog_data [0:15];
    logic        dlog_we [0:15];

    always @(negedge clk) begin
        if (!rstn) begin
            cyc_n <= 0; ret_cnt <= 0; nf <= 0; nd <= 0; irun <= 0; drun <= 0;
            max_irun <= 0; max_drun <= 0; iaddr_bad <= 0;
        end else begin
            cyc_n <= cyc_n + 1;
            if (retire) begin
                ret_cnt <= ret_cnt + 1;
                if (ret_cnt < 32) rcyc[ret_cnt] <= cyc_n + 1;
            end
            if (ibus_req) begin
                if (irun == 0) irun_addr <= ibus_addr;
                else if (ibus_addr != irun_addr) iaddr_bad <= iaddr_bad + 1;
                if (irun + 1 > max_irun) max_irun <= irun + 1;
                irun <= ibus_ack ? 0 : irun + 1;
                if (ibus_ack) begin
                    if (nf < 32) flog[nf] <= ibus_addr;
                    nf <= nf + 1;
                end
            end else irun <= 0;
            if (dbus_req) begin
                if (drun + 1 > max_drun) max_drun <= drun + 1;
                drun <= dbus_ack ? 0 : drun + 1;
                if (dbus_ack) begin
                    if (nd < 16) begin
                        dlog_addr[nd] <= dbus_addr;
                        dlog_data[nd] <= dbus_wdata;
                        dlog_we[nd]   <= dbus_we;
                    end
                    nd <= nd + 1;
                end
            end else drun <= 0;
        end
    end

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(input int op, input int rd, input int rs1, input int rs2);
        return {op[4:0], 1'b0, rd[3:0], rs1[3:0], rs2[3:0], 14'd0};
    endfunction

    function automatic logic [31:0] enc_i(input int op, input int rd, input int rs1,
                                          input logic [1:0] md, input logic [15:0] imm);
        return {op[4:0], 1'b1, rd[3:0], rs1[3:0], md, imm};
    endfunction

    function automatic logic [31:0] enc_b(input int op, input logic [26:0] off);
        return {op[4:0], off};
    endfunction

    task automatic clear_imem();
        for (int k = 0; k < 256; k++) imem[k] = HALT_W;
    endtask

    task automatic restart();
        @(negedge clk);
        rstn = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rstn = 1'b1;
    endtask

    task automatic wait_halt(input string nm, input int budget);
        for (int k = 0; k < budget && !halted; k++) @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk({nm, "_halted"}, {31'd0, halted}, 32'd1);
    endtask

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [17];

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0, busy;
        logic [31:0] exp_f [15];

        vecs[0]  = '{5'd0,  32'd5,          32'd7,          32'd12};
        vecs[1]  = '{5'd0,  32'hFFFF_FFFF,  32'd1,          32'd0};
        vecs[2]  = '{5'd1,  32'd5,          32'd7,          32'hFFFF_FFFE};
        vecs[3]  = '{5'd2,  32'h0001_0000,  32'h0001_0000,  32'd0};
        vecs[4]  = '{5'd2,  32'hFFFF_FFFD,  32'd7,          32'hFFFF_FFEB};
        vecs[5]  = '{5'd3,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD};
        vecs[6]  = '{5'd3,  32'd7,          32'd0,          32'hFFFF_FFFF};
        vecs[7]  = '{5'd3,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000};
        vecs[8]  = '{5'd4,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF};
        vecs[9]  = '{5'd4,  32'd7,          32'd0,          32'd7};
        vecs[10] = '{5'd6,  32'hF0F0_F0F0,  32'hFF00_FF00,  32'hF000_F000};
        vecs[11] = '{5'd7,  32'h0000_000F,  32'h0000_00F0,  32'h0000_00FF};
        vecs[12] = '{5'd8,  32'h1111_1111,  32'h0000_FFFF,  32'hFFFF_0000};
        vecs[13] = '{5'd9,  32'h1111_1111,  32'h1234_5678,  32'h1234_5678};
        vecs[14] = '{5'd10, 32'd1,          32'd35,         32'd8};
        vecs[15] = '{5'd11, 32'h8000_0000,  32'd31,         32'd1};
        vecs[16] = '{5'd12, 32'h8000_0000,  32'd4,          32'hF800_0000};

        // Reset state
        rstn = 1'b0;
        clear_imem();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ibus_req",   {31'd0, ibus_req}, 32'd0);
        chk("rst_ibus_addr",  ibus_addr, 32'h0);
        chk("rst_dbus_req",   {31'd0, dbus_req}, 32'd0);
        chk("rst_dbus_we",    {31'd0, dbus_we}, 32'd0);
        chk("rst_dbus_addr",  dbus_addr, 32'h0);
        chk("rst_dbus_wdata", dbus_wdata, 32'h0);
        chk("rst_retire",     {31'd0, retire}, 32'd0);
        chk("rst_halted",     {31'd0, halted}, 32'd0);
        chk("rst_alu_debug",  alu_debug, 32'h0);
        chk("rst_cyc_count",  cyc_count, 32'h0);
        chk("rst_instret",    instret, 32'h0);

        // ALU vector table: load a, b as 32-bit constants, operate, store result
        for (int i = 0; i < 17; i++) begin
            clear_imem();
            imem[0] = enc_i(9, 1, 0, 2'b10, vecs[i].a[31:16]);
            imem[1] = enc_i(7, 1, 1, 2'b01, vecs[i].a[15:0]);
            imem[2] = enc_i(9, 2, 0, 2'b10, vecs[i].b[31:16]);
            imem[3] = enc_i(7, 2, 2, 2'b01, vecs[i].b[15:0]);
            imem[4] = enc_r(int'(vecs[i].op), 3, 1, 2);
            imem[5] = enc_i(15, 3, 0, 2'b00, 16'h0040);
            restart();
            wait_halt($sformatf("vec%0d", i), 100);
            chk($sformatf("vec%0d_alu_debug", i), alu_debug, vecs[i].exp);
            chk($sformatf("vec%0d_store", i), dlog_data[0], vecs[i].exp);
        end

        // Zero-wait add program: 3 retires by cycle 6
        clear_imem();
        imem[0] = enc_i(9, 1, 0, 2'b00, 16'd5);
        imem[1] = enc_i(9, 2, 0, 2'b00, 16'd7);
        imem[2] = enc_r(0, 3, 1, 2);
        imem[3] = enc_i(15, 3, 0, 2'b00, 16'h0080);
        restart();
        wait_halt("add0", 100);
        chk("add0_ret1_cycle", rcyc[0], 32'd2);
        chk("add0_ret3_cycle", rcyc[2], 32'd6);
        chk("add0_retires",    ret_cnt, 32'd4);
        chk("add0_alu_debug",  alu_debug, 32'd12);
        chk("add0_st_addr",    dlog_addr[0], 32'h80);
        chk("add0_st_data",    dlog_data[0], 32'd12);
`ifdef SRISC_PERF_CNT_EN
        chk("perf_instret",    instret, ret_cnt);
        chk("perf_cyc_count",  cyc_count, 32'd11);
`else
        chk("perf_instret_tied",   instret, 32'd0);
        chk("perf_cyc_count_tied", cyc_count, 32'd0);
`endif

        // Same program, 3 fetch wait states
        iwait = 3;
        restart();
        wait_halt("add3", 200);
        chk("add3_first_ret_cycle", rcyc[0], 32'd5);
        chk("add3_ret3_cycle",      rcyc[2], 32'd15);
        chk("add3_req_len",         max_irun, 32'd4);
        chk("add3_addr_stable",     iaddr_bad, 32'd0);
        chk("add3_alu_debug",       alu_debug, 32'd12);
        iwait = 0;

        // Branches, call/ret, backward branch; observed via fetch addresses
        clear_imem();
        imem[0]  = enc_i(9, 1, 0, 2'b00, 16'd5);
        imem[1]  = enc_i(9, 2, 0, 2'b00, 16'd7);
        imem[2]  = enc_r(5, 0, 1, 2);
        imem[3]  = enc_b(17, 27'd2);
        imem[4]  = enc_r(5, 0, 2, 1);
        imem[5]  = enc_b(17, 27'd2);
        imem[7]  = enc_b(16, 27'd2);
        imem[8]  = enc_b(19, 27'd4);
        imem[9]  = enc_i(15, 15, 0, 2'b00, 16'h0080);
        imem[10] = enc_b(18, 27'd3);
        imem[12] = enc_r(20, 0, 0, 0);
        imem[13] = enc_r(5, 0, 1, 1);
        imem[14] = enc_b(16, 27'd2);
        imem[16] = enc_b(18, 27'h7FF_FFFF);
        exp_f = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14, 32'h1C, 32'h20,
                  32'h30, 32'h24, 32'h28, 32'h34, 32'h38, 32'h40, 32'h3C};
        restart();
        wait_halt("br", 200);
        chk("br_fetch_count", nf, 32'd15);
        for (int k = 0; k < 15; k++) chk($sformatf("br_fetch%0d", k), flog[k], exp_f[k]);
        chk("br_call_link", dlog_data[0], 32'h24);

        // Loads and stores, 2 data wait states, immediate modifiers
        clear_imem();
        imem[0]  = enc_i(9, 0, 0, 2'b00, 16'h0100);
        imem[1]  = enc_i(9, 1, 0, 2'b10, 16'hDEAD);
        imem[2]  = enc_i(7, 1, 1, 2'b01, 16'hBEEF);
        imem[3]  = enc_i(15, 1, 0, 2'b00, 16'h0004);
        imem[4]  = enc_i(14, 5, 0, 2'b00, 16'h0004);
        imem[5]  = enc_i(15, 5, 0, 2'b00, 16'h0008);
        imem[6]  = enc_i(9, 4, 0, 2'b00, 16'h8000);
        imem[7]  = enc_i(15, 4, 0, 2'b00, 16'h000C);
        imem[8]  = enc_i(9, 6, 0, 2'b01, 16'h8000);
        imem[9]  = enc_i(15, 6, 0, 2'b00, 16'h0010);
        dwait = 2;
        ld_data = 32'h0000_1234;
        restart();
        wait_halt("mem", 300);
        chk("mem_count",    nd, 32'd5);
        chk("mem_st_we",    {31'd0, dlog_we[0]}, 32'd1);
        chk("mem_st_addr",  dlog_addr[0], 32'h104);
        chk("mem_st_data",  dlog_data[0], 32'hDEAD_BEEF);
        chk("mem_ld_we",    {31'd0, dlog_we[1]}, 32'd0);
        chk("mem_ld_addr",  dlog_addr[1], 32'h104);
        chk("mem_ld_value", dlog_data[2], 32'h0000_1234);
        chk("mem_st2_addr", dlog_addr[2], 32'h108);
        chk("mem_sext_imm", dlog_data[3], 32'hFFFF_8000);
        chk("mem_zext_imm", dlog_data[4], 32'h0000_8000);
        chk("mem_req_len",  max_drun, 32'd3);
        chk("mem_retires",  ret_cnt, 32'd10);

        // Halted core stays quiet
        r0 = ret_cnt;
        busy = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (ibus_req || dbus_req || retire || !halted) busy++;
        end
        chk("halt_quiet",  busy, 32'd0);
        chk("halt_retire", ret_cnt, r0);

        // Reset in the middle of a long data access
        clear_imem();
        imem[0] = enc_r(13, 0, 0, 0);
        imem[1] = enc_r(13, 0, 0, 0);
        imem[2] = enc_r(13, 0, 0, 0);
        imem[3] = enc_i(14, 5, 0, 2'b00, 16'h0044);
        dwait = 20;
        restart();
        for (int k = 0; k < 40 && !dbus_req; k++) @(negedge clk);
        chk("rmid_dbus_req",  {31'd0, dbus_req}, 32'd1);
        chk("rmid_dbus_addr", dbus_addr, 32'h44);
        chk("rmid_pc",        ibus_addr, 32'h0C);
        rstn = 1'b0;
        #1;
        chk("rmid_dbus_req_drop", {31'd0, dbus_req}, 32'd0);
        chk("rmid_ibus_req_drop", {31'd0, ibus_req}, 32'd0);
        chk("rmid_dbus_addr_clr", dbus_addr, 32'h0);
        chk("rmid_pc_reset",      ibus_addr, 32'h0);
        @(posedge clk);
        #1 rstn = 1'b1;
        #1;
        chk("rmid_release_addr", ibus_addr, 32'h0);
        chk("rmid_release_req",  {31'd0, ibus_req}, 32'd1);
        dwait = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/simplerisc_mc_core.md
Name: simplerisc_mc_core

Overview:
- Multi-cycle SimpleRISC core; next generation of the single-cycle top.
- Replaces the internal imem/dmem with separate req/ack instruction and data bus ports, so wait-state memories can stall the core.
- Register file and store-data/RA reads use dedicated internal read ports; no hierarchical access.
- Adds parametrised reset vector, bus address width, illegal-opcode halt, and a retire pulse.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
ADDR_W, 32, width of ibus_addr/dbus_addr (low ADDR_W bits of byte address; 2..32)
HALT_ON_ILLEGAL, 1, 1: opcode 21..31 halts core; 0: treated as nop

Ports:
clk  in  1  clock, rising edge
rstn  in  1  asynchronous active-low reset
ibus_req  out  1  instruction fetch request
ibus_addr  out  ADDR_W  fetch byte address (= pc)
ibus_ack  in  1  fetch complete; ibus_rdata valid this cycle
ibus_rdata  in  32  instruction word
dbus_req  out  1  data access request
dbus_we  out  1  1 = store, 0 = load
dbus_addr  out  ADDR_W  data byte address
dbus_wdata  out  32  store data
dbus_ack  in  1  data access complete; dbus_rdata valid on loads
dbus_rdata  in  32  load data
retire  out  1  one-cycle pulse per completed instruction
halted  out  1  core stopped on illegal opcode
alu_debug  out  32  registered ALU result of last executed instruction
cyc_count  out  32  cycle counter (feature-dependent)
instret  out  32  retired-instruction counter (feature-dependent)

Behaviour:
- Reset (async, rstn=0):
  - pc=RESET_PC; state=FETCH; r0..r15=0; flags E=GT=0.
  - All outputs 0 except ibus_addr=RESET_PC[ADDR_W-1:0].
  - Reset mid-access abandons the transaction; req drops immediately.
- Encoding:
  - op=[31:27], I=[26], rd=[25:22], rs1=[21:18], rs2=[17:14], imm=[17:0].
  - Modifier imm[17:16]: 00 = sext(imm[15:0]); 01 = zext(imm[15:0]); 10 = imm[15:0]<<16; 11 = sext.
  - off27=[26:0]; target = pc + sext(off27<<2), 32-bit wrap.
- Opcodes: add0 sub1 mul2 div3 mod4 cmp5 and6 or7 not8 mov9 lsl10 lsr11 asr12 nop13 ld14 st15 beq16 bgt17 b18 call19 ret20.
- ALU:
  - 32-bit with wrap-around.
  - mul keeps the low 32 bits.
  - div and mod are signed, truncating toward zero. div by 0 = 32'hFFFFFFFF; mod by 0 = rs1.
  - Shifts use opB[4:0].
  - not/mov operate on opB only.
- States:
  - FETCH:
    - ibus_req=1, ibus_addr=pc, held stable until ibus_ack.
    - On ack, latch instr and go to EXEC.
    - A zero-wait ack in the first req cycle is legal.
  - EXEC (exactly 1 cycle):
    - ALU, cmp, mov, not: write rd (r0 is an ordinary register). cmp writes only E and GT.
    - Flags: E=(rs1==opB); GT=signed(rs1)>signed(opB).
    - Branches use the flag values held before this instruction.
    - call: write r15=pc+4; pc=target.
    - ret: pc=r15.
    - Taken beq/bgt/b: pc=target; otherwise pc=pc+4.
    - retire=1 and go to FETCH.
    - ld/st: latch dbus_addr=rs1+immx, dbus_we, dbus_wdata=reg[rd]; go to MEM; no retire yet.
    - Illegal opcode with HALT_ON_ILLEGAL=1: go to HALT; pc unchanged; no retire.
  - MEM:
    - dbus_req=1 with addr/we/wdata stable until dbus_ack.
    - On ack: ld writes rd=dbus_rdata; pc+=4; retire=1; go to FETCH.
  - HALT: terminal. halted=1, no bus requests. Exit only via reset.
- Latency: non-memory instruction = fetch wait + 2 cycles (FETCH, EXEC) with zero-wait memory; ld/st = 3 cycles.
- req deasserts in the cycle after ack is sampled; ack while req=0 is ignored.
- alu_debug updates in EXEC only.

Optional Feature:
- Macro SRISC_PERF_CNT_EN.
- Defined:
  - cyc_count increments every clock while not halted and not in reset.
  - instret increments with each retire pulse.
  - Both are 32-bit, wrap 0xFFFFFFFF→0, and reset to 0.
- Undefined: cyc_count and instret are tied to 0 and no counter flops are built.

Test Plan:
- Zero-wait memory, program "mov r1,5; mov r2,7; add r3,r1,r2" at 0x0 -> r3=12, three retire pulses, alu_debug=12, 6 cycles total.
- Fetch with 3 wait states per ack -> ibus_addr and ibus_req stable for 4 cycles; same final r3=12; no early retire.
- "cmp r1,r2" (5 vs 7) then "bgt +2" -> not taken, pc=8 next; then "cmp r2,r1; bgt +2" at pc=0x10 -> pc=0x18.
- "call +4" at 0x20 -> r15=0x24, pc=0x30; "ret" at 0x30 -> pc=0x24.
- "st r1,4[r0]" with r0=0x100 and r1=0xDEADBEEF -> dbus_we=1, addr=0x104, wdata=0xDEADBEEF. "ld r5,4[r0]" with dbus_rdata=0x1234 and 2 wait states -> r5=0x1234.
- Opcode 31 fetched -> halted=1 next cycle, ibus_req=0 forever. Reset asserted mid-dbus_req -> req=0 immediately, and after release ibus_addr=RESET_PC. With SRISC_PERF_CNT_EN defined, instret equals the number of retire pulses.
